// File: rtl/riscv_pkg.sv
// Shared RV32 encodings, immediate decoding and branch-compare helpers
// for the decode stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [1:0]  BHT_RESET = 2'b01;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_4;
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
  } id_ex_t;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: t = IMM_I;
      OPC_STORE:                                  t = IMM_S;
      OPC_BRANCH:                                 t = IMM_B;
      OPC_LUI, OPC_AUIPC:                         t = IMM_U;
      OPC_JAL:                                    t = IMM_J;
      OPC_OP:                                     t = IMM_R;
      default:                                    t = IMM_R;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'h000};
      IMM_J:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Unlisted funct3 encodings resolve as not taken.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic t;
    case (funct3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = ($signed(a) <  $signed(b));
      F3_BGE:  t = ($signed(a) >= $signed(b));
      F3_BLTU: t = (a <  b);
      F3_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two read ports and one write port, with x0 tied to
// zero and write-through bypass on same-cycle read/write.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        wren,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (wren && (waddr != 5'd0)) regs_d[waddr] = wdata;
  end

  // NOTE: this storage is flop-based and must clear on reset, so it cannot map
  // to a RAM macro; a RAM-backed file would drop the reset loop entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (wren && (waddr == raddr1)) rdata1 = wdata;
    if (wren && (waddr == raddr2)) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// File: rtl/stage_id_bhv.sv
// Decode stage: IF/ID and ID/EX registers, global-history branch predictor,
// branch resolution with redirect, jump target generation and register read.
module stage_id_bhv
  import riscv_pkg::*;
#(
  parameter int GHR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_4,
  input  logic [31:0] inst,
  input  logic        ctrl_branch,
  input  logic        hold,
  input  logic        wb_wren,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        default_branch,
  output logic        branch_override,
  output logic [31:0] correct_addr,
  output logic        ctrl_jump,
  output logic [31:0] jump_addr,
  output logic        ex_valid,
  output logic [31:0] ex_PC_4,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd
);

  localparam int BHT_N = 1 << GHR_W;

  logic [31:0]      id_pc_4_q, id_pc_4_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic             id_branch_q, id_branch_d;
  logic             id_valid_q, id_valid_d;
  logic             id_pred_taken_q, id_pred_taken_d;
  logic [GHR_W-1:0] id_pred_idx_q, id_pred_idx_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [1:0]       bht_q [BHT_N];
  logic [1:0]       bht_d [BHT_N];
  id_ex_t           ex_q, ex_d;

  logic [6:0]  opcode;
  imm_type_e   imm_type;
  logic [31:0] imm, b_imm, br_target;
  logic [31:0] rs1_data, rs2_data;
  logic        taken, resolve, is_jal, is_jalr, flush;

  assign opcode = id_inst_q[6:0];

  regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (id_inst_q[19:15]),
    .raddr2 (id_inst_q[24:20]),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .wren   (wb_wren),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  always_comb begin
    imm_type  = imm_type_of(opcode);
    imm       = imm_gen(id_inst_q, imm_type);
    b_imm     = imm_gen(id_inst_q, IMM_B);
    br_target = id_pc_4_q + b_imm;
    taken     = branch_taken(id_inst_q[14:12], rs1_data, rs2_data);
    is_jal    = (opcode == OPC_JAL);
    is_jalr   = (opcode == OPC_JALR);
    resolve   = id_valid_q & id_branch_q & ~hold & ~rst;
  end

  // Redirects are suppressed during reset and hold so the fetch side never
  // acts on a decision that this stage is not committing.
  always_comb begin
    default_branch  = ~rst & bht_q[ghr_q][1];
    branch_override = resolve & (taken ^ id_pred_taken_q);
    correct_addr    = '0;
    if (branch_override) correct_addr = taken ? br_target : id_pc_4_q;
    ctrl_jump = id_valid_q & (is_jal | is_jalr) & ~hold & ~rst;
    jump_addr = '0;
    if (ctrl_jump) begin
      jump_addr = is_jal ? (id_pc_4_q - 32'd4) + imm
                         : (rs1_data + imm) & ~32'd1;
    end
    flush = branch_override | ctrl_jump;
  end

  // NOTE: every signal assigned here gets a value on every path (hold is the
  // default), otherwise synthesis would infer a latch.
  always_comb begin
    id_pc_4_d       = id_pc_4_q;
    id_inst_d       = id_inst_q;
    id_branch_d     = id_branch_q;
    id_valid_d      = id_valid_q;
    id_pred_taken_d = id_pred_taken_q;
    id_pred_idx_d   = id_pred_idx_q;
    if (!hold) begin
      if (flush) begin
        id_pc_4_d       = '0;
        id_inst_d       = NOP_INST;
        id_branch_d     = 1'b0;
        id_valid_d      = 1'b0;
        id_pred_taken_d = 1'b0;
        id_pred_idx_d   = '0;
      end else begin
        id_pc_4_d       = PC_4;
        id_inst_d       = inst;
        id_branch_d     = ctrl_branch;
        id_valid_d      = 1'b1;
        id_pred_taken_d = default_branch;
        id_pred_idx_d   = ghr_q;
      end
    end
  end

  // Counters train at the index the prediction was made with, not the
  // current history, since the history may have moved on in between.
  always_comb begin
    bht_d = bht_q;
    ghr_d = ghr_q;
    if (resolve) begin
      if (taken && (bht_q[id_pred_idx_q] != 2'b11)) begin
        bht_d[id_pred_idx_q] = bht_q[id_pred_idx_q] + 2'd1;
      end else if (!taken && (bht_q[id_pred_idx_q] != 2'b00)) begin
        bht_d[id_pred_idx_q] = bht_q[id_pred_idx_q] - 2'd1;
      end
      ghr_d = (ghr_q << 1) | GHR_W'(taken);
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (!hold) begin
      ex_d.valid    = id_valid_q;
      ex_d.pc_4     = id_pc_4_q;
      ex_d.inst     = id_inst_q;
      ex_d.rs1_data = rs1_data;
      ex_d.rs2_data = rs2_data;
      ex_d.imm      = imm;
      ex_d.rd       = ((opcode == OPC_BRANCH) || (opcode == OPC_STORE)) ? 5'd0
                                                                       : id_inst_q[11:7];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_4_q       <= '0;
      id_inst_q       <= NOP_INST;
      id_branch_q     <= 1'b0;
      id_valid_q      <= 1'b0;
      id_pred_taken_q <= 1'b0;
      id_pred_idx_q   <= '0;
      ghr_q           <= '0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= BHT_RESET;
      ex_q            <= '0;
    end else begin
      id_pc_4_q       <= id_pc_4_d;
      id_inst_q       <= id_inst_d;
      id_branch_q     <= id_branch_d;
      id_valid_q      <= id_valid_d;
      id_pred_taken_q <= id_pred_taken_d;
      id_pred_idx_q   <= id_pred_idx_d;
      ghr_q           <= ghr_d;
      bht_q           <= bht_d;
      ex_q            <= ex_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_PC_4     = ex_q.pc_4;
  assign ex_inst     = ex_q.inst;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rd       = ex_q.rd;

endmodule

// File: tb/tb_stage_id_bhv.sv
// Scoreboard bench for stage_id_bhv: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the decode stage.
module tb_stage_id_bhv;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] PC_4 = '0, inst = NOP, wb_data = '0;
  logic ctrl_branch = 1'b0, hold = 1'b0, wb_wren = 1'b0;
  logic [4:0] wb_rd = '0;
  logic default_branch, branch_override, ctrl_jump, ex_valid;
  logic [31:0] correct_addr, jump_addr, ex_PC_4, ex_inst, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rd;

  always #5 clk = ~clk;

  stage_id_bhv #(.GHR_W(4)) dut (
    .clk(clk), .rst(rst), .PC_4(PC_4), .inst(inst), .ctrl_branch(ctrl_branch),
    .hold(hold), .wb_wren(wb_wren), .wb_rd(wb_rd), .wb_data(wb_data),
    .default_branch(default_branch), .branch_override(branch_override),
    .correct_addr(correct_addr), .ctrl_jump(ctrl_jump), .jump_addr(jump_addr),
    .ex_valid(ex_valid), .ex_PC_4(ex_PC_4), .ex_inst(ex_inst),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd)
  );

  typedef struct {
    logic [66:0]  comb;
    logic [165:0] ex;
    bit           ex_chk;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: architectural view of the stage.
  logic [31:0] m_regs [32];
  int          m_bht [16];
  logic [3:0]  m_ghr;
  logic [31:0] m_id_pc4, m_id_inst;
  bit          m_id_br, m_id_valid, m_id_pred;
  logic [3:0]  m_id_idx;
  logic [165:0] m_ex = '0;
  bit          m_warm = 1'b0;
  logic [31:0] pc = 32'h1000;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] imm_of(input logic [31:0] i);
    logic signed [31:0] s;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: s = 32'($signed(i[31:20]));
      7'b0100011: s = 32'($signed({i[31:25], i[11:7]}));
      7'b1100011: s = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      7'b0110111, 7'b0010111: s = {i[31:12], 12'h000};
      7'b1101111: s = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: s = 0;
    endcase
    return s;
  endfunction

  function automatic bit resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] idx, input bit we,
                                         input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wr == idx) return wd;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  // One clock of stimulus: drive, predict this cycle's outputs, advance the model.
  task automatic step(input bit r, input logic [31:0] pc4, input logic [31:0] ins,
                      input bit h, input bit we, input logic [4:0] wr, input logic [31:0] wd);
    logic [31:0] a, b, corr, jaddr, imm;
    logic [6:0] op;
    logic [3:0] ghr_old;
    bit tk, dflt, ovr, jmp;
    @(posedge clk);
    #1;
    rst = r; PC_4 = pc4; inst = ins; ctrl_branch = (ins[6:0] == OP_BRANCH);
    hold = h; wb_wren = we; wb_rd = wr; wb_data = wd;

    op = m_id_inst[6:0];
    a = rd_reg(m_id_inst[19:15], we, wr, wd);
    b = rd_reg(m_id_inst[24:20], we, wr, wd);
    tk = resolve(m_id_inst[14:12], a, b);
    imm = imm_of(m_id_inst);
    dflt = 0; ovr = 0; corr = 0; jmp = 0; jaddr = 0;
    if (!r) begin
      dflt = (m_bht[m_ghr] >= 2);
      ovr = m_id_valid && m_id_br && (tk != m_id_pred) && !h;
      if (ovr) corr = tk ? m_id_pc4 + imm_of({m_id_inst[31:7], OP_BRANCH}) : m_id_pc4;
      jmp = m_id_valid && (op == OP_JAL || op == OP_JALR) && !h;
      if (jmp) jaddr = (op == OP_JAL) ? m_id_pc4 - 4 + imm : (a + imm) & 32'hFFFF_FFFE;
    end
    exp_q.push_back('{comb: {dflt, ovr, corr, jmp, jaddr}, ex: m_ex, ex_chk: m_warm});

    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
      m_ghr = 0; m_ex = 0; m_warm = 1;
      m_id_pc4 = 0; m_id_inst = NOP; m_id_br = 0; m_id_valid = 0; m_id_pred = 0; m_id_idx = 0;
    end else begin
      if (!h) begin
        ghr_old = m_ghr;
        m_ex = {m_id_valid, m_id_pc4, m_id_inst, a, b, imm,
                (op == OP_BRANCH || op == OP_STORE) ? 5'd0 : m_id_inst[11:7]};
        if (m_id_valid && m_id_br) begin
          if (tk) m_bht[m_id_idx] = (m_bht[m_id_idx] == 3) ? 3 : m_bht[m_id_idx] + 1;
          else    m_bht[m_id_idx] = (m_bht[m_id_idx] == 0) ? 0 : m_bht[m_id_idx] - 1;
          m_ghr = {m_ghr[2:0], tk};
        end
        if (ovr || jmp) begin
          m_id_pc4 = 0; m_id_inst = NOP; m_id_br = 0; m_id_valid = 0; m_id_pred = 0; m_id_idx = 0;
        end else begin
          m_id_pc4 = pc4; m_id_inst = ins; m_id_br = (ins[6:0] == OP_BRANCH);
          m_id_valid = 1; m_id_pred = dflt; m_id_idx = ghr_old;
        end
      end
      if (we && wr != 0) m_regs[wr] = wd;
    end
  endtask

  task automatic filler(input bit we = 0, input logic [4:0] wr = 0, input logic [31:0] wd = 0);
    pc = pc + 4;
    step(0, pc, NOP, 0, we, wr, wd);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 11))
      0, 1, 2, 3: i[6:0] = OP_BRANCH;
      4:  i[6:0] = 7'b0110011;
      5:  i[6:0] = OP_IMM;
      6:  i[6:0] = 7'b0000011;
      7:  i[6:0] = OP_STORE;
      8:  i[6:0] = ($urandom_range(0, 1) != 0) ? 7'b0110111 : 7'b0010111;
      9:  i[6:0] = OP_JAL;
      10: i[6:0] = OP_JALR;
      default: i = NOP;
    endcase
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 3));
      2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("comb_outputs",
            {125'd0, default_branch, branch_override, correct_addr, ctrl_jump, jump_addr},
            {125'd0, e.comb});
      if (e.ex_chk)
        check("id_ex_reg",
              {26'd0, ex_valid, ex_PC_4, ex_inst, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd},
              {26'd0, e.ex});
    end
  end

  initial begin
    logic [31:0] beq, bltu, blt, jalr, rd_x5, rd_x0;
    step(1, 0, NOP, 0, 0, 0, 0);
    step(1, 0, NOP, 0, 1, 5'd4, 32'h55);
    #2;
    check("reset_outputs", {default_branch, branch_override, ctrl_jump, correct_addr, jump_addr}, 67'd0);

    filler(1, 1, 5); filler(1, 2, 5); filler(1, 3, 32'h200);
    filler(1, 6, 32'hFFFF_FFFF); filler(1, 7, 1);

    // Repeated taken BEQ: history fills with ones, then one entry trains to 3.
    beq = enc_b(3'b000, 1, 2, 13'd16);
    for (int k = 0; k < 8; k++) begin
      step(0, 32'h104, beq, 0, 0, 0, 0);
      #2; check("beq_fetch_pred", default_branch, (k >= 5));
      filler();
      #2; check("beq_override", branch_override, (k < 5));
      check("beq_correct_addr", correct_addr, (k < 5) ? 32'h114 : 32'h0);
      if (k == 0) begin
        filler(); #2;
        check("beq_in_ex", {ex_valid, ex_inst, ex_rd}, {1'b1, beq, 5'd0});
        filler(); #2;
        check("flushed_nop_in_ex", {ex_valid, ex_inst}, {1'b0, NOP});
      end
    end

    bltu = enc_b(3'b110, 6, 7, 13'd32);
    step(0, 32'h200, bltu, 0, 0, 0, 0); #2; check("bltu_pred", default_branch, 1'b1);
    filler(); #2;
    check("bltu_override", branch_override, 1'b1);
    check("bltu_correct_addr", correct_addr, 32'h200);
    blt = enc_b(3'b100, 6, 7, 13'd32);
    step(0, 32'h300, blt, 0, 0, 0, 0); #2; check("blt_pred", default_branch, 1'b0);
    filler(); #2;
    check("blt_override", branch_override, 1'b1);
    check("blt_correct_addr", correct_addr, 32'h320);

    jalr = enc_i(OP_JALR, 3'b000, 5'd1, 5'd3, 12'd7);
    step(0, 32'h400, jalr, 0, 0, 0, 0);
    filler(); #2;
    check("jalr_jump", {ctrl_jump, jump_addr}, {1'b1, 32'h206});
    filler(); #2;
    check("jalr_ex_rd", ex_rd, 5'd1);
    check("jalr_flushed", ctrl_jump, 1'b0);

    rd_x5 = enc_i(OP_IMM, 3'b000, 5'd8, 5'd5, 12'd0);
    step(0, 32'h600, rd_x5, 0, 0, 0, 0);
    filler(1, 5, 32'hDEAD);
    filler(); #2; check("bypass_x5", ex_rs1_data, 32'hDEAD);
    rd_x0 = enc_i(OP_IMM, 3'b000, 5'd9, 5'd0, 12'd0);
    step(0, 32'h610, rd_x0, 0, 0, 0, 0);
    filler(1, 0, 32'h1234);
    filler(); #2; check("x0_bypass_blocked", ex_rs1_data, 32'h0);
    step(0, 32'h620, rd_x0, 0, 0, 0, 0);
    filler(); filler(); #2; check("x0_reads_zero", ex_rs1_data, 32'h0);

    // Mispredicted branch frozen in ID by hold; redirect fires when hold drops.
    step(0, 32'h500, beq, 0, 0, 0, 0); #2; check("hold_br_pred", default_branch, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(0, 32'h700, NOP, 1, 0, 0, 0); #2;
      check("hold_no_override", {branch_override, correct_addr}, 33'd0);
    end
    step(0, 32'h704, NOP, 0, 0, 0, 0); #2;
    check("hold_release_override", {branch_override, correct_addr}, {1'b1, 32'h510});
    filler();

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), $urandom, rand_inst(),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) != 0),
           5'($urandom_range(0, 7)), rand_data());
    end

    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
